// File: rtl/result_requant_reader_if.sv
// result_requant_reader_if: BRAM port-B read bus and int8 output stream of the result reader
interface result_requant_reader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8
);
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic [OUT_W-1:0]  o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;
  modport master (output o_rd_en, o_rd_addr, o_data, o_valid, o_last, input i_rd_data, i_ready);
  modport slave  (input o_rd_en, o_rd_addr, o_data, o_valid, o_last, output i_rd_data, i_ready);
endinterface

// File: rtl/result_requant_reader.sv
// result_requant_reader: drains the int32 result BRAM, requantizes to int8 and streams with credit-based backpressure
module result_requant_reader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 8,
  parameter int RD_LAT = 2,
  parameter int FIFO_D = 4
) (
  input  logic                     i_clk,
  input  logic                     i_arst,
  input  logic                     i_start,
  input  logic [4:0]               i_shift,
  result_requant_reader_if.master  bus,
  output logic                     o_busy,
  output logic                     o_done
);
  localparam int CW = $clog2(FIFO_D + 1);
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam logic signed [DATA_W:0] SMAX = (DATA_W+1)'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [DATA_W:0] SMIN = ~SMAX;
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;
  state_t                  r_state, w_next;
  logic [ADDR_W-1:0]       r_addr, r_beat;
  logic [4:0]              r_shift;
  logic [RD_LAT-1:0]       r_vld;
  logic [CW-1:0]           r_inflight, r_cnt;
  logic [DATA_W-1:0]       r_mem [FIFO_D];
  logic [PW-1:0]           r_wp, r_rp;
  logic                    w_rd_en, w_push, w_pop, w_valid, w_last, w_last_issue;
  logic [CW:0]             w_occ;
  logic signed [DATA_W:0]  w_rnd, w_sum, w_t;
  assign w_occ        = (CW+1)'(r_inflight) + (CW+1)'(r_cnt);
  assign w_push       = r_vld[RD_LAT-1];
  assign w_valid      = r_cnt != '0;
  assign w_pop        = w_valid && bus.i_ready;
  assign w_last       = w_valid && r_beat == ADDR_W'(DEPTH - 1);
  assign w_last_issue = w_rd_en && r_addr == ADDR_W'(DEPTH - 1);
  assign bus.o_rd_en   = w_rd_en;
  assign bus.o_rd_addr = r_addr;
  assign bus.o_valid   = w_valid;
  assign bus.o_last    = w_last;
  // pass state register
  always_ff @(posedge i_clk or negedge i_arst)
    if (!i_arst) r_state <= IDLE;
    else r_state <= w_next;
  // pass sequencing: start, issue all reads, drain until last beat accepted, pulse done
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = READ;
      READ:    if (w_last_issue) w_next = DRAIN;
      DRAIN:   if (w_pop && w_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // reads are issued only while outstanding data plus buffered data leaves room in the FIFO
  always_comb begin
    w_rd_en = r_state == READ && w_occ < (CW+1)'(FIFO_D);
    o_busy  = r_state != IDLE;
    o_done  = r_state == DONE;
  end
  // read address, beat counter, latched shift and return-data tagging
  always_ff @(posedge i_clk or negedge i_arst)
    if (!i_arst) begin
      r_addr     <= '0;
      r_beat     <= '0;
      r_shift    <= '0;
      r_vld      <= '0;
      r_inflight <= '0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_addr  <= '0;
        r_beat  <= '0;
        r_shift <= i_shift;
      end else begin
        if (w_rd_en && !w_last_issue) r_addr <= r_addr + ADDR_W'(1);
        if (w_pop) r_beat <= r_beat + ADDR_W'(1);
      end
      r_vld      <= (r_vld << 1) | RD_LAT'(w_rd_en);
      r_inflight <= r_inflight + CW'(w_rd_en) - CW'(w_push);
    end
  // return buffer storage
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= bus.i_rd_data;
  // return buffer pointers and occupancy
  always_ff @(posedge i_clk or negedge i_arst)
    if (!i_arst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= (r_wp == PW'(FIFO_D - 1)) ? '0 : r_wp + PW'(1);
      if (w_pop) r_rp <= (r_rp == PW'(FIFO_D - 1)) ? '0 : r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  // rounding shift in DATA_W+1 bits then saturation, applied to the FIFO head
  always_comb begin
    w_rnd      = (r_shift == '0) ? '0 : (DATA_W+1)'(1) << (r_shift - 5'd1);
    w_sum      = $signed({r_mem[r_rp][DATA_W-1], r_mem[r_rp]}) + w_rnd;
    w_t        = w_sum >>> r_shift;
    bus.o_data = !w_valid ? '0 : (w_t > SMAX) ? OUT_W'(SMAX) : (w_t < SMIN) ? OUT_W'(SMIN) : w_t[OUT_W-1:0];
  end
endmodule

// File: tb/tb_result_requant_reader.sv
// tb_result_requant_reader: randomized pass-level checks of the result reader against an arithmetic model
module tb_result_requant_reader;
  localparam int DEPTH = 1024, ADDR_W = 10, DATA_W = 32, OUT_W = 8, RD_LAT = 2, FIFO_D = 4;
  logic clk = 0, arst_n = 0, start = 0, ready = 1, busy, done;
  logic [4:0] shift = 0;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] pipe [RD_LAT];
  int checks = 0, failures = 0;
  int beats, issued, dones, pass_shift, cyc = 0, start_cyc, first_valid_cyc, last_acc_cyc, mode = 0;
  int got [8];
  logic seen_valid = 0, prev_stall = 0, prev_last = 0;
  logic [OUT_W-1:0] prev_data = 0;
  always #5 clk = ~clk;
  result_requant_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();
  result_requant_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W),
                          .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .i_clk(clk), .i_arst(arst_n), .i_start(start), .i_shift(shift),
    .bus(bus), .o_busy(busy), .o_done(done));
  assign bus.i_ready   = ready;
  assign bus.i_rd_data = pipe[RD_LAT-1];
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    pipe[0] <= bus.o_rd_en ? mem[bus.o_rd_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  task automatic check(string tag, longint obs, longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  function automatic int ref_byte(logic [31:0] w, int s);
    longint x = longint'($signed(w));
    longint t = (s == 0) ? x : (x + (longint'(1) << (s - 1))) >>> s;
    return t > 127 ? 127 : t < -128 ? -128 : int'(t);
  endfunction
  initial forever begin
    @(posedge clk);
    #2;
    ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 99) < 30) : 1'b0;
  end
  always @(negedge clk)
    if (!arst_n) prev_stall = 0;
    else begin
      if (bus.o_rd_en) begin
        check("rd_addr", bus.o_rd_addr, issued);
        issued++;
        check("credit", int'(issued - beats <= FIFO_D), 1);
      end
      if (bus.o_valid && !seen_valid) begin
        seen_valid = 1;
        first_valid_cyc = cyc;
      end
      if (bus.o_valid && prev_stall) begin
        check("hold_data", bus.o_data, prev_data);
        check("hold_last", bus.o_last, prev_last);
      end
      if (bus.o_valid && ready) begin
        if (beats >= DEPTH) check("overrun", beats, DEPTH - 1);
        else begin
          check("data", $signed(bus.o_data), ref_byte(mem[beats], pass_shift));
          check("last", bus.o_last, beats == DEPTH - 1);
          if (beats < 8) got[beats] = $signed(bus.o_data);
        end
        beats++;
        last_acc_cyc = cyc;
      end
      prev_stall = bus.o_valid && !ready;
      prev_data  = bus.o_data;
      prev_last  = bus.o_last;
      if (done) begin
        check("done_gap", cyc - last_acc_cyc, 1);
        dones++;
      end
    end
  task automatic pulse(input int s);
    @(posedge clk);
    #1;
    start = 1;
    shift = 5'(s);
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic run_pass(input int s);
    beats = 0;
    issued = 0;
    dones = 0;
    seen_valid = 0;
    pass_shift = s;
    pulse(s);
    start_cyc = cyc;
  endtask
  task automatic wait_beats(input int n);
    int k = 0;
    while (beats < n && k < 20000) begin
      @(posedge clk);
      k++;
    end
    check("reach_beat", int'(beats >= n), 1);
  endtask
  task automatic wait_done();
    int k = 0;
    while (dones == 0 && k < 20000) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", int'(dones > 0), 1);
    repeat (5) @(posedge clk);
    #1;
    check("done_once", dones, 1);
    check("beats", beats, DEPTH);
    check("issued", issued, DEPTH);
    check("busy_idle", busy, 0);
  endtask
  task automatic check_zero(string tag);
    check({tag, "_rd_en"}, bus.o_rd_en, 0);
    check({tag, "_rd_addr"}, bus.o_rd_addr, 0);
    check({tag, "_data"}, bus.o_data, 0);
    check({tag, "_valid"}, bus.o_valid, 0);
    check({tag, "_last"}, bus.o_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask
  task automatic fill(input bit ramp);
    for (int a = 0; a < DEPTH; a++) mem[a] = ramp ? DATA_W'(a) : DATA_W'($urandom);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    arst_n = 1;
    fill(1);
    run_pass(0);
    wait_done();
    check("latency", first_valid_cyc - start_cyc, RD_LAT + 1);
    fill(0);
    mem[0] = 24;
    mem[1] = 23;
    mem[2] = -24;
    mem[3] = -25;
    mem[4] = 32'h7FFF_FFFF;
    mem[5] = 32'h8000_0000;
    run_pass(4);
    wait_done();
    check("rnd_24", got[0], 2);
    check("rnd_23", got[1], 1);
    check("rnd_m24", got[2], -1);
    check("rnd_m25", got[3], -2);
    check("sat_max", got[4], 127);
    check("sat_min", got[5], -128);
    fill(1);
    mode = 1;
    run_pass(0);
    wait_done();
    fill(0);
    mode = 2;
    run_pass(0);
    repeat (50) @(posedge clk);
    #1;
    check("stall_issued", issued, FIFO_D);
    check("stall_valid", bus.o_valid, 1);
    check("stall_rd_en", bus.o_rd_en, 0);
    mode = 0;
    wait_done();
    fill(0);
    mode = 1;
    run_pass($urandom_range(1, 10));
    wait_beats(500);
    pulse(7);
    wait_done();
    fill(0);
    run_pass(3);
    wait_beats(300);
    @(posedge clk);
    #1;
    arst_n = 0;
    #1;
    check_zero("abort");
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", dones, 0);
    arst_n = 1;
    fill(1);
    mode = 0;
    run_pass(0);
    wait_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
